// File: rtl/color_sel_pkg.sv
// Package: color_sel_pkg
// Shared types and constants for the RGB colour selector.
//   channel_e    : channel selector encoding (R=0, G=1, B=2; 3 is never used)
//   OLED_*       : panel geometry and last-pixel coordinates for the scan counters
//   CMD_*        : ASCII command bytes accepted on the UART receive path
//   next_channel : R -> G -> B -> R rotation
//   step_sat     : saturating step of one 8-bit channel by the DIP step size
package color_sel_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  localparam int OLED_COLS = 96;
  localparam int OLED_ROWS = 64;
  localparam logic [6:0] COL_LAST = 7'(OLED_COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(OLED_ROWS - 1);

  localparam logic [7:0] CMD_R   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_G   = 8'h47;  // 'G'
  localparam logic [7:0] CMD_B   = 8'h42;  // 'B'
  localparam logic [7:0] CMD_INC = 8'h2B;  // '+'
  localparam logic [7:0] CMD_DEC = 8'h2D;  // '-'

  function automatic channel_e next_channel(input channel_e c);
    case (c)
      CH_R:    return CH_G;
      CH_G:    return CH_B;
      default: return CH_R;
    endcase
  endfunction

  // A step size of zero means one. The 9th bit is the carry (inc) or the
  // borrow (dec), so it flags exactly the cases that must clamp.
  function automatic logic [7:0] step_sat(input logic [7:0] v,
                                          input logic [7:0] dip,
                                          input logic       up);
    logic [8:0] s;
    logic [8:0] r;
    s = (dip == 8'd0) ? 9'd1 : {1'b0, dip};
    if (up) begin
      r = {1'b0, v} + s;
      return r[8] ? 8'hFF : r[7:0];
    end else begin
      r = {1'b0, v} - s;
      return r[8] ? 8'h00 : r[7:0];
    end
  endfunction

endpackage

// File: rtl/color_selector_wrapper_pb_edge_detect.sv
// Module: pb_edge_detect
// Two-flop synchroniser followed by a rising-edge detector, per bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i[N]     : raw asynchronous inputs (active-high)
//   rise_o[N]  : one-cycle pulse, asserted in the second cycle after d_i rises
//                so the consumer's register updates on the third edge
module pb_edge_detect #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;
  logic [N-1:0] prev_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // High for exactly one cycle per press however long the button is held.
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/color_selector_wrapper.sv
// Module: color_selector_wrapper
// Board wrapper for a hardwired RGB colour selector. PB[2] increments and
// PB[0] decrements the selected channel by the DIP[7:0] step (0 -> 1) with
// saturation; PB[1] rotates the selection R->G->B. The colour is shown on
// LED_OUT (selected channel), LED_PC (one-hot selection), SEVENSEGHEX
// ({6'b0, sel, R, G, B}) and is painted over the full 96x64 OLED every frame.
// Optional build macro COLOR_UART_EN: report each change over UART_TX with a
// held valid, and accept 'R'/'G'/'B'/'+'/'-' commands on UART_RX. Without
// the macro the UART outputs are held at zero and UART_RX is ignored.
// ACCEL_Data is ignored and ACCEL_DReady is tied low.
module color_selector_wrapper
  import color_sel_pkg::*;
#(
  parameter int N_LEDs_OUT = 8,
  parameter int N_DIPs     = 16,
  parameter int N_PBs      = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_DIPs-1:0]     DIP,
  input  logic [N_PBs-1:0]      PB,
  output logic [N_LEDs_OUT-1:0] LED_OUT,
  output logic [6:0]            LED_PC,
  output logic [31:0]           SEVENSEGHEX,
  output logic [7:0]            UART_TX,
  input  logic                  UART_TX_ready,
  output logic                  UART_TX_valid,
  input  logic [7:0]            UART_RX,
  input  logic                  UART_RX_valid,
  output logic                  UART_RX_ack,
  output logic                  OLED_Write,
  output logic [6:0]            OLED_Col,
  output logic [5:0]            OLED_Row,
  output logic [23:0]           OLED_Data,
  input  logic [31:0]           ACCEL_Data,
  output logic                  ACCEL_DReady
);

  logic [N_PBs-1:0] pb_rise;
  logic             inc_pb, next_pb, dec_pb;

  pb_edge_detect #(.N(N_PBs)) u_pb_edge (
    .clk    (CLK),
    .rst_n  (RESET),
    .d_i    (PB),
    .rise_o (pb_rise)
  );

  assign inc_pb  = pb_rise[2];
  assign next_pb = pb_rise[1];
  assign dec_pb  = pb_rise[0];

  // Channel storage indexed by channel_e: [0]=R, [1]=G, [2]=B.
  logic [2:0][7:0] ch_q, ch_d;
  channel_e        sel_q, sel_d;
  logic [7:0]      led_out_q;
  logic [6:0]      led_pc_q;
  logic            do_inc, do_dec;
  logic            rx_accept;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    ch_d   = ch_q;
    sel_d  = sel_q;
    do_inc = 1'b0;
    do_dec = 1'b0;
    // A next edge swallows any inc/dec edge in the same cycle, and inc+dec
    // together cancel. Any button edge also blocks a UART command that cycle.
    if (next_pb) begin
      sel_d = next_channel(sel_q);
    end else if (inc_pb || dec_pb) begin
      do_inc = inc_pb & ~dec_pb;
      do_dec = dec_pb & ~inc_pb;
    end else if (rx_accept) begin
      case (UART_RX)
        CMD_R:   sel_d  = CH_R;
        CMD_G:   sel_d  = CH_G;
        CMD_B:   sel_d  = CH_B;
        CMD_INC: do_inc = 1'b1;
        CMD_DEC: do_dec = 1'b1;
        default: ;
      endcase
    end
    if (do_inc) ch_d[sel_q] = step_sat(ch_q[sel_q], DIP[7:0], 1'b1);
    if (do_dec) ch_d[sel_q] = step_sat(ch_q[sel_q], DIP[7:0], 1'b0);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ch_q      <= '0;
      sel_q     <= CH_R;
      led_out_q <= '0;
      led_pc_q  <= 7'h01;
    end else begin
      ch_q      <= ch_d;
      sel_q     <= sel_d;
      led_out_q <= ch_d[sel_d];
      led_pc_q  <= {4'b0, sel_d == CH_B, sel_d == CH_G, sel_d == CH_R};
    end
  end

  assign LED_OUT     = N_LEDs_OUT'(led_out_q);
  assign LED_PC      = led_pc_q;
  assign SEVENSEGHEX = {6'b0, sel_q, ch_q[CH_R], ch_q[CH_G], ch_q[CH_B]};

`ifdef COLOR_UART_EN
  logic [7:0] tx_q;
  logic       tx_valid_q;
  logic       rx_ack_q;
  logic       changed;

  // Accept on alternate cycles so a source holding valid until it sees the
  // ack is not taken twice.
  assign rx_accept = UART_RX_valid & ~rx_ack_q;
  assign changed   = (ch_d != ch_q) || (sel_d != sel_q);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_q       <= '0;
      tx_valid_q <= 1'b0;
      rx_ack_q   <= 1'b0;
    end else begin
      rx_ack_q <= rx_accept;
      // A newer change overwrites a pending byte and keeps valid asserted.
      if (changed) begin
        tx_q       <= ch_d[sel_d];
        tx_valid_q <= 1'b1;
      end else if (UART_TX_ready) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign UART_TX       = tx_q;
  assign UART_TX_valid = tx_valid_q;
  assign UART_RX_ack   = rx_ack_q;
`else
  assign rx_accept     = 1'b0;
  assign UART_TX       = '0;
  assign UART_TX_valid = 1'b0;
  assign UART_RX_ack   = 1'b0;

  logic unused_uart;
  assign unused_uart = ^{UART_RX, UART_RX_valid, UART_TX_ready};
`endif

  // Raster scan: write_q rises on the first edge after reset, and the
  // counters only advance while it is high so pixel (0,0) is written first.
  logic       write_q;
  logic [6:0] col_q;
  logic [5:0] row_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      write_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      write_q <= 1'b1;
      if (write_q) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? 6'd0 : row_q + 6'd1;
        end else begin
          col_q <= col_q + 7'd1;
        end
      end
    end
  end

  assign OLED_Write   = write_q;
  assign OLED_Col     = col_q;
  assign OLED_Row     = row_q;
  assign OLED_Data    = {ch_q[CH_R], ch_q[CH_G], ch_q[CH_B]};
  assign ACCEL_DReady = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{DIP[N_DIPs-1:8], ACCEL_Data};

endmodule

// File: tb/tb_color_selector_wrapper.sv
// Testbench for color_selector_wrapper: directed button sequences with
// hand-computed colour states, saturation and same-cycle priority cases,
// a full OLED frame scan, and the UART path for whichever build is selected.
module tb_color_selector_wrapper;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] DIP = 16'h0000;
  logic [2:0]  PB = 3'b000;
  logic [7:0]  LED_OUT;
  logic [6:0]  LED_PC;
  logic [31:0] SEVENSEGHEX;
  logic [7:0]  UART_TX;
  logic        UART_TX_ready = 1'b1;
  logic        UART_TX_valid;
  logic [7:0]  UART_RX = 8'h00;
  logic        UART_RX_valid = 1'b0;
  logic        UART_RX_ack;
  logic        OLED_Write;
  logic [6:0]  OLED_Col;
  logic [5:0]  OLED_Row;
  logic [23:0] OLED_Data;
  logic [31:0] ACCEL_Data = 32'h0;
  logic        ACCEL_DReady;

  int checks = 0;
  int errors = 0;

  color_selector_wrapper dut (
    .CLK(CLK), .RESET(RESET), .DIP(DIP), .PB(PB),
    .LED_OUT(LED_OUT), .LED_PC(LED_PC), .SEVENSEGHEX(SEVENSEGHEX),
    .UART_TX(UART_TX), .UART_TX_ready(UART_TX_ready), .UART_TX_valid(UART_TX_valid),
    .UART_RX(UART_RX), .UART_RX_valid(UART_RX_valid), .UART_RX_ack(UART_RX_ack),
    .OLED_Write(OLED_Write), .OLED_Col(OLED_Col), .OLED_Row(OLED_Row),
    .OLED_Data(OLED_Data), .ACCEL_Data(ACCEL_Data), .ACCEL_DReady(ACCEL_DReady)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [2:0] pb);
    PB = pb;
    tick(22);
    PB = 3'b000;
    tick(6);
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (SEVENSEGHEX !== 32'h0) begin errors++; $display("FAIL reset_7seg got %h exp %h", SEVENSEGHEX, 32'h0); end
    checks++; if (LED_PC !== 7'h01) begin errors++; $display("FAIL reset_led_pc got %h exp %h", LED_PC, 7'h01); end
    checks++; if (OLED_Write !== 1'b0 || UART_TX_valid !== 1'b0 || UART_RX_ack !== 1'b0 || ACCEL_DReady !== 1'b0)
      begin errors++; $display("FAIL reset_strobes got %b%b%b%b exp 0000", OLED_Write, UART_TX_valid, UART_RX_ack, ACCEL_DReady); end
    RESET = 1'b1;
    tick(1);
    checks++; if ({OLED_Write, OLED_Col, OLED_Row} !== {1'b1, 7'd0, 6'd0})
      begin errors++; $display("FAIL first_write got w=%b c=%0d r=%0d exp w=1 c=0 r=0", OLED_Write, OLED_Col, OLED_Row); end
    tick(1);
    checks++; if (OLED_Col !== 7'd1) begin errors++; $display("FAIL col_step got %0d exp 1", OLED_Col); end
  endtask

  task automatic test_inc_latency;
    PB = 3'b100;
    tick(2);
    checks++; if (SEVENSEGHEX !== 32'h0) begin errors++; $display("FAIL inc_too_early got %h exp %h", SEVENSEGHEX, 32'h0); end
    tick(1);
    checks++; if (SEVENSEGHEX !== 32'h00010000) begin errors++; $display("FAIL inc_third_edge got %h exp %h", SEVENSEGHEX, 32'h00010000); end
    tick(19);
    PB = 3'b000;
    tick(6);
    checks++; if (SEVENSEGHEX !== 32'h00010000) begin errors++; $display("FAIL inc_once got %h exp %h", SEVENSEGHEX, 32'h00010000); end
    checks++; if (LED_OUT !== 8'h01) begin errors++; $display("FAIL inc_led got %h exp %h", LED_OUT, 8'h01); end
  endtask

  task automatic test_select;
    press(3'b010);
    press(3'b100);
    press(3'b010);
    press(3'b100);
    checks++; if (SEVENSEGHEX !== 32'h02010101) begin errors++; $display("FAIL select_7seg got %h exp %h", SEVENSEGHEX, 32'h02010101); end
    checks++; if (LED_PC !== 7'h04) begin errors++; $display("FAIL select_led_pc got %h exp %h", LED_PC, 7'h04); end
    press(3'b010);
    checks++; if ({LED_PC, SEVENSEGHEX} !== {7'h01, 32'h00010101})
      begin errors++; $display("FAIL select_wrap got %h/%h exp 01/00010101", LED_PC, SEVENSEGHEX); end
  endtask

  task automatic test_saturate;
    DIP = 16'h00FF;
    press(3'b100);
    checks++; if (SEVENSEGHEX !== 32'h00FF0101) begin errors++; $display("FAIL sat_inc1 got %h exp %h", SEVENSEGHEX, 32'h00FF0101); end
    press(3'b100);
    checks++; if ({LED_OUT, SEVENSEGHEX} !== {8'hFF, 32'h00FF0101})
      begin errors++; $display("FAIL sat_inc2 got %h/%h exp ff/00ff0101", LED_OUT, SEVENSEGHEX); end
    press(3'b010);
    press(3'b001);
    checks++; if (SEVENSEGHEX !== 32'h01FF0001) begin errors++; $display("FAIL sat_dec1 got %h exp %h", SEVENSEGHEX, 32'h01FF0001); end
    press(3'b001);
    checks++; if ({LED_OUT, SEVENSEGHEX} !== {8'h00, 32'h01FF0001})
      begin errors++; $display("FAIL sat_dec2 got %h/%h exp 00/01ff0001", LED_OUT, SEVENSEGHEX); end
  endtask

  task automatic test_step;
    DIP = 16'hAB03;  // upper byte must be ignored
    press(3'b010);
    press(3'b100);
    checks++; if (SEVENSEGHEX !== 32'h02FF0004) begin errors++; $display("FAIL step3 got %h exp %h", SEVENSEGHEX, 32'h02FF0004); end
    DIP = 16'h0000;
  endtask

  task automatic test_same_cycle;
    press(3'b110);
    checks++; if ({LED_PC, SEVENSEGHEX} !== {7'h01, 32'h00FF0004})
      begin errors++; $display("FAIL next_over_inc got %h/%h exp 01/00ff0004", LED_PC, SEVENSEGHEX); end
    press(3'b101);
    checks++; if (SEVENSEGHEX !== 32'h00FF0004) begin errors++; $display("FAIL inc_dec_cancel got %h exp %h", SEVENSEGHEX, 32'h00FF0004); end
  endtask

  task automatic test_uart;
`ifdef COLOR_UART_EN
    UART_TX_ready = 1'b0;
    press(3'b001);
    checks++; if ({UART_TX_valid, UART_TX} !== {1'b1, 8'hFE})
      begin errors++; $display("FAIL tx_load got v=%b d=%h exp v=1 d=fe", UART_TX_valid, UART_TX); end
    tick(5);
    checks++; if (UART_TX_valid !== 1'b1) begin errors++; $display("FAIL tx_hold got %b exp 1", UART_TX_valid); end
    UART_TX_ready = 1'b1;
    tick(1);
    checks++; if (UART_TX_valid !== 1'b0) begin errors++; $display("FAIL tx_drain got %b exp 0", UART_TX_valid); end
    UART_RX = 8'h42;
    UART_RX_valid = 1'b1;
    tick(1);
    UART_RX_valid = 1'b0;
    checks++; if ({UART_RX_ack, SEVENSEGHEX[25:24], UART_TX} !== {1'b1, 2'b10, 8'h04})
      begin errors++; $display("FAIL rx_b got ack=%b sel=%0d tx=%h exp ack=1 sel=2 tx=04", UART_RX_ack, SEVENSEGHEX[25:24], UART_TX); end
    tick(1);
    checks++; if (UART_RX_ack !== 1'b0) begin errors++; $display("FAIL rx_ack_pulse got %b exp 0", UART_RX_ack); end
    UART_RX = 8'h52;
    UART_RX_valid = 1'b1;
    tick(1);
    UART_RX_valid = 1'b0;
    tick(2);
`else
    UART_RX = 8'h42;
    UART_RX_valid = 1'b1;
    tick(2);
    UART_RX_valid = 1'b0;
    checks++; if ({UART_RX_ack, UART_TX_valid, UART_TX} !== 10'h0)
      begin errors++; $display("FAIL uart_off got ack=%b v=%b d=%h exp 0/0/00", UART_RX_ack, UART_TX_valid, UART_TX); end
    checks++; if (SEVENSEGHEX !== 32'h00FF0004) begin errors++; $display("FAIL rx_ignored got %h exp %h", SEVENSEGHEX, 32'h00FF0004); end
    press(3'b001);
`endif
    checks++; if (SEVENSEGHEX !== 32'h00FE0004) begin errors++; $display("FAIL uart_end got %h exp %h", SEVENSEGHEX, 32'h00FE0004); end
  endtask

  task automatic test_oled;
    int n = 0;
    int writes = 0;
    int scan_bad = 0;
    int wraps = 0;
    logic [6:0] ec = 7'd0;
    logic [5:0] er = 6'd0;
    while (!(OLED_Col == 7'd0 && OLED_Row == 6'd0) && n < 7000) begin
      tick(1);
      n++;
    end
    checks++; if (n >= 7000) begin errors++; $display("FAIL frame_start_timeout got %0d cycles exp < 7000", n); end
    for (int i = 0; i < 6144; i++) begin
      if (OLED_Write === 1'b1) writes++;
      if (OLED_Col !== ec || OLED_Row !== er || OLED_Data !== 24'hFE0004) scan_bad++;
      if (ec == 7'd95) begin
        ec = 7'd0;
        er = (er == 6'd63) ? 6'd0 : er + 6'd1;
        if (er != 6'd0) wraps++;
      end else begin
        ec = ec + 7'd1;
      end
      tick(1);
    end
    checks++; if (writes != 6144) begin errors++; $display("FAIL frame_writes got %0d exp 6144", writes); end
    checks++; if (scan_bad != 0) begin errors++; $display("FAIL scan_order got %0d bad pixels exp 0", scan_bad); end
    checks++; if (wraps != 63) begin errors++; $display("FAIL row_wraps got %0d exp 63", wraps); end
    checks++; if ({OLED_Col, OLED_Row} !== 13'd0)
      begin errors++; $display("FAIL frame_wrap got c=%0d r=%0d exp 0/0", OLED_Col, OLED_Row); end
    press(3'b001);
    checks++; if (OLED_Data !== 24'hFD0004) begin errors++; $display("FAIL data_tracks got %h exp %h", OLED_Data, 24'hFD0004); end
  endtask

  initial begin
    test_reset();
    test_inc_latency();
    test_select();
    test_saturate();
    test_step();
    test_same_cycle();
    test_uart();
    test_oled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
